// File: rtl/huffman_merge_arbiter_pkg.sv
// Shared widths, latencies and types for the Huffman merge arbiter and its
// downstream code/literal merge pipeline.
package huffman_merge_pkg;

  localparam int HUFF_CODE_W   = 16;
  localparam int HUFF_LEN_W    = 4;
  localparam int LIT_W         = 11;
  localparam int LIT_LEN_W     = 4;
  localparam int MERGE_LATENCY = 5;
  localparam int MERGED_W      = 27;
  localparam int MERGED_LEN_W  = 5;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [HUFF_CODE_W-1:0] code;
    logic [HUFF_LEN_W-1:0]  code_len;
    logic [LIT_W-1:0]       literal;
    logic [LIT_LEN_W-1:0]   literal_len;
  } huff_beat_t;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/huffman_merge_arbiter_if.sv
// Requester, credit-return, merge-pipeline and status signals of the arbiter,
// bundled so the arbiter and its environment share one port list.
interface huffman_merge_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int TAG_W   = 2
);
  import huffman_merge_pkg::*;

  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ-1:0]             req_last;
  logic [HUFF_CODE_W*NUM_REQ-1:0] req_code;
  logic [HUFF_LEN_W*NUM_REQ-1:0]  req_code_len;
  logic [LIT_W*NUM_REQ-1:0]       req_literal;
  logic [LIT_LEN_W*NUM_REQ-1:0]   req_literal_len;
  logic [NUM_REQ-1:0]             cons_pop;

  logic                   m_valid;
  logic [HUFF_CODE_W-1:0] m_code;
  logic [HUFF_LEN_W-1:0]  m_code_len;
  logic [LIT_W-1:0]       m_literal;
  logic [LIT_LEN_W-1:0]   m_literal_len;

  logic             out_tag_valid;
  logic [TAG_W-1:0] out_tag;
  logic             credit_err;
  logic             busy;

  modport master (
    input  req_valid, req_last, req_code, req_code_len, req_literal,
           req_literal_len, cons_pop,
    output req_ready, m_valid, m_code, m_code_len, m_literal, m_literal_len,
           out_tag_valid, out_tag, credit_err, busy
  );

  modport slave (
    output req_valid, req_last, req_code, req_code_len, req_literal,
           req_literal_len, cons_pop,
    input  req_ready, m_valid, m_code, m_code_len, m_literal, m_literal_len,
           out_tag_valid, out_tag, credit_err, busy
  );

endinterface

// File: rtl/huffman_merge_arbiter_tag_delay.sv
// Fixed-depth valid+tag shift register that tracks the merge pipeline so the
// requester index emerges alongside the pipeline's out_valid.
module huffman_tag_delay
  import huffman_merge_pkg::*;
#(
  parameter int DEPTH = MERGE_LATENCY,
  parameter int TAG_W = 2
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  output logic [TAG_W-1:0] out_tag,
  output logic             any_valid
);

  logic [DEPTH-1:0] valid_sr;
  logic [TAG_W-1:0] tag_sr [DEPTH];

  always_ff @(posedge clk) begin
    if (clear) begin
      valid_sr <= '0;
      for (int i = 0; i < DEPTH; i++) tag_sr[i] <= '0;
    end else begin
      valid_sr[0] <= in_valid;
      tag_sr[0]   <= in_tag;
      for (int i = 1; i < DEPTH; i++) begin
        valid_sr[i] <= valid_sr[i-1];
        tag_sr[i]   <= tag_sr[i-1];
      end
    end
  end

  assign out_valid = valid_sr[DEPTH-1];
  assign out_tag   = tag_sr[DEPTH-1];
  assign any_valid = |valid_sr;

endmodule

// File: rtl/huffman_merge_arbiter.sv
// Packet-granular round-robin arbiter with per-requester credit gating that
// feeds one shared Huffman code/literal merge pipeline.
//   state     | meaning
//   ST_IDLE   | no packet open; grant searched from rr_ptr upward
//   ST_LOCKED | packet from lock_idx open; only lock_idx may be granted
module huffman_merge_arbiter
  import huffman_merge_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int CREDITS      = 8,
  parameter int PIPE_LATENCY = MERGE_LATENCY,
  parameter int TAG_W        = 2
) (
  input logic                    clk,
  input logic                    rst,
  huffman_merge_arbiter_if.master bus
);

  localparam int CRED_W = $clog2(CREDITS + 1);
  localparam logic [CRED_W-1:0] CRED_FULL = CRED_W'(CREDITS);

  arb_state_e       state, state_next;
  logic [TAG_W-1:0] lock_idx, rr_ptr, grant_idx;
  logic             grant_valid;
  logic [CRED_W-1:0] credit [NUM_REQ];
  logic [NUM_REQ-1:0] has_credit, ready, accept;
  logic             accept_any, accept_last;
  huff_beat_t       sel_beat, m_beat_q;
  logic             m_valid_q;
  logic [TAG_W-1:0] m_tag_q;
  logic             credit_err_q;
  logic             tag_busy;

  always_comb begin
    has_credit = '0;
    for (int r = 0; r < NUM_REQ; r++) has_credit[r] = (credit[r] != '0);
  end

  // Descending search so the candidate closest to rr_ptr is written last and wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    if (state == ST_LOCKED) begin
      grant_idx = lock_idx;
      for (int r = 0; r < NUM_REQ; r++)
        if (lock_idx == TAG_W'(r)) grant_valid = has_credit[r];
    end else begin
      for (int i = NUM_REQ - 1; i >= 0; i--)
        for (int r = 0; r < NUM_REQ; r++)
          if ((((int'(rr_ptr) + i) % NUM_REQ) == r) && bus.req_valid[r] && has_credit[r]) begin
            grant_valid = 1'b1;
            grant_idx   = TAG_W'(r);
          end
    end
  end

  always_comb begin
    ready = '0;
    for (int r = 0; r < NUM_REQ; r++)
      ready[r] = !rst && grant_valid && (grant_idx == TAG_W'(r));
  end

  assign accept     = ready & bus.req_valid;
  assign accept_any = |accept;

  always_comb begin
    sel_beat    = '0;
    accept_last = 1'b0;
    for (int r = 0; r < NUM_REQ; r++)
      if (accept[r]) begin
        sel_beat.code        = bus.req_code[r*HUFF_CODE_W +: HUFF_CODE_W];
        sel_beat.code_len    = bus.req_code_len[r*HUFF_LEN_W +: HUFF_LEN_W];
        sel_beat.literal     = bus.req_literal[r*LIT_W +: LIT_W];
        sel_beat.literal_len = bus.req_literal_len[r*LIT_LEN_W +: LIT_LEN_W];
        accept_last          = bus.req_last[r];
      end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (accept_any && !accept_last) state_next = ST_LOCKED;
      ST_LOCKED: if (accept_any && accept_last)  state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_idx  <= '0;
      rr_ptr    <= '0;
      m_valid_q <= 1'b0;
      m_tag_q   <= '0;
      m_beat_q  <= '0;
    end else begin
      m_valid_q <= accept_any;
      if (accept_any) begin
        m_beat_q <= sel_beat;
        m_tag_q  <= grant_idx;
        if (accept_last) rr_ptr   <= TAG_W'(rr_next(int'(grant_idx), NUM_REQ));
        else             lock_idx <= grant_idx;
      end
    end
  end

  // Accept and pop in the same cycle cancel; a pop at full credit is a protocol error.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REQ; r++) credit[r] <= CRED_FULL;
      credit_err_q <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REQ; r++) begin
        case ({accept[r], bus.cons_pop[r]})
          2'b10: credit[r] <= credit[r] - CRED_W'(1);
          2'b01: begin
            if (credit[r] == CRED_FULL) credit_err_q <= 1'b1;
            else                        credit[r]    <= credit[r] + CRED_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

  huffman_tag_delay #(
    .DEPTH (PIPE_LATENCY),
    .TAG_W (TAG_W)
  ) u_tag_delay (
    .clk       (clk),
    .clear     (rst),
    .in_valid  (m_valid_q),
    .in_tag    (m_tag_q),
    .out_valid (bus.out_tag_valid),
    .out_tag   (bus.out_tag),
    .any_valid (tag_busy)
  );

  assign bus.req_ready     = ready;
  assign bus.m_valid       = m_valid_q;
  assign bus.m_code        = m_beat_q.code;
  assign bus.m_code_len    = m_beat_q.code_len;
  assign bus.m_literal     = m_beat_q.literal;
  assign bus.m_literal_len = m_beat_q.literal_len;
  assign bus.credit_err    = credit_err_q;
  assign bus.busy          = (state == ST_LOCKED) || m_valid_q || tag_busy;

endmodule

// File: tb/tb_huffman_merge_arbiter.sv
// Directed bench for the Huffman merge arbiter: grants, lock bubbles, credit
// gating, credit overflow and mid-packet reset, with a merged-word/tag scoreboard.
module tb_huffman_merge_arbiter;
  import huffman_merge_pkg::*;

  localparam int NUM_REQ      = 2;
  localparam int CREDITS      = 8;
  localparam int PIPE_LATENCY = 5;
  localparam int TAG_W        = 2;

  typedef struct {
    int          due;
    logic [15:0] code;
    logic [3:0]  code_len;
    logic [10:0] literal;
    logic [3:0]  literal_len;
  } exp_beat_t;

  typedef struct {
    int               due;
    logic [TAG_W-1:0] tag;
  } exp_tag_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  huffman_merge_arbiter_if #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) bus ();

  huffman_merge_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .CREDITS      (CREDITS),
    .PIPE_LATENCY (PIPE_LATENCY),
    .TAG_W        (TAG_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_beat_t dq[$];
  exp_tag_t  tq[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  int bc[NUM_REQ];
  int seq[NUM_REQ];
  int pkt_len[NUM_REQ];
  logic [NUM_REQ-1:0] t1_ready [9];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", name, obs, exp, cyc);
    end
  endtask

  function automatic exp_beat_t beat_of(input int r, input int s, input int due);
    exp_beat_t b;
    b.due         = due;
    b.code        = 16'(32'hA000 + r * 32'h1000 + s * 7);
    b.code_len    = 4'(s + r);
    b.literal     = 11'(s * 37 + r * 5);
    b.literal_len = 4'(s * 3 + r);
    return b;
  endfunction

  task automatic apply_lanes();
    exp_beat_t b;
    for (int r = 0; r < NUM_REQ; r++) begin
      b = beat_of(r, seq[r], 0);
      bus.req_last[r]                 = (bc[r] == pkt_len[r] - 1);
      bus.req_code[r*16 +: 16]        = b.code;
      bus.req_code_len[r*4 +: 4]      = b.code_len;
      bus.req_literal[r*11 +: 11]     = b.literal;
      bus.req_literal_len[r*4 +: 4]   = b.literal_len;
    end
  endtask

  // One clock: check ready (masked by care), book expected outputs for the
  // beats the model accepts, then advance those lanes to their next beat.
  task automatic step(input logic [NUM_REQ-1:0] exp_ready, input logic [NUM_REQ-1:0] care,
                      input string name);
    logic [NUM_REQ-1:0] acc;
    exp_tag_t t;
    @(negedge clk);
    check(name, 32'(bus.req_ready & care), 32'(exp_ready & care));
    acc = exp_ready & bus.req_valid;
    for (int r = 0; r < NUM_REQ; r++)
      if (acc[r]) begin
        dq.push_back(beat_of(r, seq[r], cyc + 1));
        t.due = cyc + 1 + PIPE_LATENCY;
        t.tag = TAG_W'(r);
        tq.push_back(t);
      end
    @(posedge clk);
    #1;
    bus.cons_pop = '0;
    for (int r = 0; r < NUM_REQ; r++)
      if (acc[r]) begin
        bc[r] = bus.req_last[r] ? 0 : bc[r] + 1;
        seq[r]++;
      end
    apply_lanes();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.cons_pop = '0;
    @(posedge clk);
    #1;
    dq.delete();
    tq.delete();
    mon_en = 1'b1;
    @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'(0));
    check("rst_m_valid", 32'(bus.m_valid), 32'(0));
    check("rst_out_tag_valid", 32'(bus.out_tag_valid), 32'(0));
    check("rst_busy", 32'(bus.busy), 32'(0));
    check("rst_credit_err", 32'(bus.credit_err), 32'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int r = 0; r < NUM_REQ; r++) bc[r] = 0;
    apply_lanes();
  endtask

  always @(negedge clk) begin : mon
    exp_beat_t b;
    exp_tag_t  t;
    logic      ev;
    if (mon_en) begin
      ev = (dq.size() > 0) && (dq[0].due == cyc);
      check("m_valid", 32'(bus.m_valid), 32'(ev));
      if (ev) begin
        b = dq.pop_front();
        check("m_code", 32'(bus.m_code), 32'(b.code));
        check("m_code_len", 32'(bus.m_code_len), 32'(b.code_len));
        check("m_literal", 32'(bus.m_literal), 32'(b.literal));
        check("m_literal_len", 32'(bus.m_literal_len), 32'(b.literal_len));
      end
      ev = (tq.size() > 0) && (tq[0].due == cyc);
      check("out_tag_valid", 32'(bus.out_tag_valid), 32'(ev));
      if (ev) begin
        t = tq.pop_front();
        check("out_tag", 32'(bus.out_tag), 32'(t.tag));
      end
    end
  end

  initial begin
    for (int r = 0; r < NUM_REQ; r++) begin
      bc[r] = 0;
      seq[r] = r * 50;
      pkt_len[r] = 1;
    end
    for (int i = 0; i < 9; i++) t1_ready[i] = (i >= 3 && i < 6) ? 2'b10 : 2'b01;
    bus.req_valid = '0;
    bus.cons_pop  = '0;
    apply_lanes();
    do_reset();

    // Round-robin with 3-beat packets on both lanes.
    pkt_len[0] = 3;
    pkt_len[1] = 3;
    bus.req_valid = 2'b11;
    apply_lanes();
    for (int i = 0; i < 9; i++) step(t1_ready[i], 2'b11, "rr_grant");
    bus.req_valid = '0;
    repeat (8) step(2'b00, 2'b11, "rr_drain");
    check("idle_busy", 32'(bus.busy), 32'(0));

    // Locked packet with a two-cycle bubble on the owner.
    do_reset();
    bus.req_valid = 2'b11;
    step(2'b01, 2'b11, "lock_b0");
    check("lock_busy", 32'(bus.busy), 32'(1));
    bus.req_valid[0] = 1'b0;
    step(2'b00, 2'b10, "bubble_l1_blocked");
    step(2'b00, 2'b10, "bubble_l1_blocked");
    bus.req_valid[0] = 1'b1;
    step(2'b01, 2'b11, "lock_b1");
    step(2'b01, 2'b11, "lock_b2_last");
    step(2'b10, 2'b11, "l1_after_last");
    bus.req_valid = '0;
    repeat (8) step(2'b00, 2'b01, "lock_drain");

    // Credit exhaustion on lane0 with single-beat packets.
    do_reset();
    pkt_len[0] = 1;
    pkt_len[1] = 1;
    bus.req_valid = 2'b01;
    apply_lanes();
    repeat (8) step(2'b01, 2'b11, "credit_accept");
    repeat (2) step(2'b00, 2'b11, "credit_empty");
    bus.cons_pop[0] = 1'b1;
    step(2'b00, 2'b11, "credit_pop_cycle");
    step(2'b01, 2'b11, "credit_pop_accept");
    step(2'b00, 2'b11, "credit_empty_again");

    // Accept and pop together hold credit at one.
    bus.req_valid = '0;
    bus.cons_pop[0] = 1'b1;
    step(2'b00, 2'b11, "refill_one");
    bus.req_valid = 2'b01;
    for (int i = 0; i < 20; i++) begin
      bus.cons_pop[0] = 1'b1;
      step(2'b01, 2'b11, "acc_and_pop");
    end
    step(2'b01, 2'b11, "acc_last_credit");
    step(2'b00, 2'b11, "credit_held_one");
    check("no_credit_err", 32'(bus.credit_err), 32'(0));
    bus.req_valid = '0;
    repeat (8) step(2'b00, 2'b11, "credit_drain");

    // Pop at full credit on lane1.
    bus.cons_pop[1] = 1'b1;
    step(2'b00, 2'b11, "pop_full");
    check("credit_err_set", 32'(bus.credit_err), 32'(1));
    bus.req_valid = 2'b10;
    repeat (8) step(2'b10, 2'b11, "l1_full_credit");
    step(2'b00, 2'b11, "l1_credit_capped");
    check("credit_err_sticky", 32'(bus.credit_err), 32'(1));
    bus.req_valid = '0;
    repeat (8) step(2'b00, 2'b11, "err_drain");

    // Reset in the middle of a 4-beat lane1 packet.
    do_reset();
    pkt_len[0] = 1;
    pkt_len[1] = 4;
    bus.req_valid = 2'b10;
    apply_lanes();
    step(2'b10, 2'b11, "mid_b0");
    step(2'b10, 2'b11, "mid_b1");
    step(2'b10, 2'b11, "mid_b2");
    do_reset();
    bus.req_valid = 2'b11;
    step(2'b01, 2'b11, "post_rst_l0_first");
    step(2'b10, 2'b11, "post_rst_l1_next");
    bus.req_valid = '0;
    repeat (8) step(2'b00, 2'b01, "final_drain");

    check("beat_queue_empty", 32'(dq.size()), 32'(0));
    check("tag_queue_empty", 32'(tq.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/huffman_merge_arbiter.md
Name: huffman_merge_arbiter

Overview:
- Shares one 5-stage Huffman-code/literal merge pipeline between NUM_REQ entropy-coder requesters, for example per-colour-component or per-tile encoder lanes.
- Arbitrates round-robin at packet granularity (a packet is a JPEG block, closed by a beat with last=1).
- Gates each requester on credits for its downstream bit-packer FIFO.
- Delays the requester tag so it emerges aligned with the merge pipeline's out_valid.

Parameters:
- NUM_REQ, 2: number of requesters (2..4).
- CREDITS, 8: per-requester downstream FIFO depth, in merged words.
- PIPE_LATENCY, 5: merge pipeline latency from in_valid to out_valid.
- TAG_W, 2: tag width; must be >= clog2(NUM_REQ).

Ports:
- clk  in  1  clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_ready  out  NUM_REQ  per-requester accept; a beat is taken when valid&ready.
- req_last  in  NUM_REQ  beat closes the packet.
- req_code  in  16*NUM_REQ  Huffman code, lane r at [16r+15:16r].
- req_code_len  in  4*NUM_REQ  code length; 0 encodes 16.
- req_literal  in  11*NUM_REQ  literal bits, right-aligned.
- req_literal_len  in  4*NUM_REQ  literal length, passed unchanged.
- cons_pop  in  NUM_REQ  one-cycle pulse: consumer r freed one FIFO entry.
- m_valid  out  1  to the merge pipeline's in_valid.
- m_code  out  16  to huff_code.
- m_code_len  out  4  to huff_code_len.
- m_literal  out  11  to literal.
- m_literal_len  out  4  to literal_len.
- out_tag_valid  out  1  aligned with the merge pipeline's out_valid.
- out_tag  out  TAG_W  requester index of the merged word currently emerging.
- credit_err  out  1  sticky: cons_pop seen with credit already at CREDITS.
- busy  out  1  packet locked, or any tag still in flight.

Behaviour:
- Reset values:
  - All outputs 0; req_ready=0.
  - credit[r]=CREDITS; rr pointer=0; unlocked; tag delay line cleared; credit_err=0.
- States:
  - IDLE (unlocked): each cycle the grant goes to the first r, searching from rr pointer upward modulo NUM_REQ, with req_valid[r]=1 and credit[r]>0.
  - LOCKED(g): only g can be granted. Others see req_ready=0 even when g is idle or out of credit (bubble, m_valid=0).
- req_ready[r] is combinational from registered state and the current-cycle arbitration: r granted, and credit[r]>0. At most one req_ready high per cycle.
- Transitions:
  - IDLE→LOCKED(g) on an accepted beat with last=0.
  - LOCKED(g)→IDLE on an accepted beat from g with last=1.
  - An accepted last=1 beat from IDLE stays IDLE (single-beat packet).
  - On every accepted last=1 beat, rr pointer ← (g+1) mod NUM_REQ.
- Issue: a beat accepted in cycle k appears on m_* registered, with m_valid=1 in cycle k+1. m_* hold their last value when m_valid=0.
- Tag: out_tag_valid/out_tag in cycle k+1+PIPE_LATENCY (k+6 by default) equal the m_valid/grant index from cycle k+1. The tag path is a pure shift register with no stall.
- Credits:
  - Accept from r: credit[r]−1.
  - cons_pop[r]: credit[r]+1.
  - Both in the same cycle: unchanged.
  - cons_pop[r] with credit[r]==CREDITS (and no same-cycle accept): credit stays at CREDITS and credit_err←1. credit_err is cleared only by rst.
- Widths: credit counters are clog2(CREDITS+1) bits and never wrap.
- Reset mid-packet: lock dropped, in-flight tags discarded (out_tag_valid=0 from the next cycle), credits restored to CREDITS. Downstream FIFOs must be reset by the same rst.
- NUM_REQ=1 degenerates to credit gating only; the lock is still tracked.

Decomposition:
- Shared package huffman_merge_pkg holds:
  - HUFF_CODE_W=16, HUFF_LEN_W=4, LIT_W=11, LIT_LEN_W=4.
  - MERGE_LATENCY=5 (default for PIPE_LATENCY), MERGED_W=27, MERGED_LEN_W=5.
- One sub-module: huffman_tag_delay, a PIPE_LATENCY-deep valid+tag shift register with synchronous clear.

Test Plan:
- Round-robin / lock:
  - Stimulus: both lanes continuously valid, 3-beat packets (last on beat 3), ample pops.
  - Required: grants follow 0,0,0,1,1,1,0,0,0, each m_valid one cycle after accept. out_tag shows the same sequence 6 cycles after each accept.
- Lock with bubble:
  - Stimulus: lane0 drops valid for 2 cycles mid-packet while lane1 is valid.
  - Required: req_ready[1]=0 and m_valid=0 for exactly those 2 cycles; lane1 is granted only after lane0's last.
- Credit exhaustion:
  - Stimulus: CREDITS=8, no pops, lane0 streams single-beat packets while lane1 is idle.
  - Required: 8 beats accepted, then req_ready[0]=0. One cons_pop[0] pulse leads to exactly one more accept.
- Simultaneous accept and pop:
  - Stimulus: credit[0]=1, accept and cons_pop[0] in the same cycle, repeated 20 cycles.
  - Required: credit stays 1 and a beat is accepted every cycle.
- Credit overflow:
  - Stimulus: cons_pop[1] at full credit.
  - Required: credit_err=1 next cycle and stays 1; credit[1]=8.
- Reset mid-packet:
  - Stimulus: rst asserted on beat 2 of a 4-beat lane1 packet with 3 tags in flight.
  - Required: next cycle out_tag_valid=0, busy=0, m_valid=0. Afterwards lane0 is granted first (rr pointer=0).
